// File: rtl/global_pred_ctrl_if.sv
// Bundle of fetch-prediction, retire-update and counter-table signals for global_pred_ctrl.
// The slave modport is the controller's view; master is the surrounding pipeline/table.
interface global_pred_ctrl_if #(
    parameter int HIST_W = 12
);
    logic              pred_req;
    logic              pred_ready;
    logic              pred_valid;
    logic              pred_taken;
    logic [HIST_W-1:0] pred_hist;

    logic              upd_req;
    logic              upd_ready;
    logic [HIST_W-1:0] upd_hist;
    logic              upd_taken;
    logic              upd_mispredict;

    logic [HIST_W-1:0] tbl_addr;
    logic              tbl_rd_en;
    logic [1:0]        tbl_rdata;
    logic              tbl_wr_en;
    logic [1:0]        tbl_wdata;

    logic [HIST_W-1:0] path_history;

    modport slave (
        input  pred_req, upd_req, upd_hist, upd_taken, upd_mispredict, tbl_rdata,
        output pred_ready, pred_valid, pred_taken, pred_hist, upd_ready,
               tbl_addr, tbl_rd_en, tbl_wr_en, tbl_wdata, path_history
    );

    modport master (
        output pred_req, upd_req, upd_hist, upd_taken, upd_mispredict, tbl_rdata,
        input  pred_ready, pred_valid, pred_taken, pred_hist, upd_ready,
               tbl_addr, tbl_rd_en, tbl_wr_en, tbl_wdata, path_history
    );
endinterface

// File: rtl/global_pred_ctrl.sv
// Global-history branch predictor controller: arbitrates a single-port 2-bit counter table
// between fetch predictions and a small queue of retire-stage saturating updates.
module global_pred_ctrl #(
    parameter int HIST_W = 12,
    parameter int QDEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    global_pred_ctrl_if.slave   bus
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        PRED_RD,
        PRED_RSP,
        UPD_RD,
        UPD_WR
    } state_t;

    state_t state, state_nxt;

    logic [HIST_W-1:0] q_hist  [QDEPTH];
    logic              q_taken [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [HIST_W-1:0] path_q;
    logic [HIST_W-1:0] pred_hist_q;
    logic              pred_taken_q;

    logic              q_full, q_empty, upd_acc, pred_acc, deq;
    logic [HIST_W-1:0] head_hist;
    logic              head_taken;

    logic              rd_en, wr_en, pred_valid;
    logic [HIST_W-1:0] addr;
    logic [1:0]        wdata;

    assign q_full     = (count == CNT_W'(QDEPTH));
    assign q_empty    = (count == '0);
    assign head_hist  = q_hist[rd_ptr];
    assign head_taken = q_taken[rd_ptr];

    assign bus.upd_ready  = !q_full;
    assign bus.pred_ready = (state == IDLE) && !q_full;
    assign upd_acc        = bus.upd_req && !q_full;
    assign pred_acc       = bus.pred_req && bus.pred_ready;
    assign deq            = (state == UPD_WR);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        addr       = '0;
        wdata      = 2'b00;
        pred_valid = 1'b0;
        case (state)
            IDLE: begin
                if (pred_acc)      state_nxt = PRED_RD;
                else if (!q_empty) state_nxt = UPD_RD;
            end
            PRED_RD: begin
                rd_en     = 1'b1;
                addr      = path_q;
                state_nxt = PRED_RSP;
            end
            PRED_RSP: begin
                pred_valid = 1'b1;
                state_nxt  = IDLE;
            end
            UPD_RD: begin
                rd_en     = 1'b1;
                addr      = head_hist;
                state_nxt = UPD_WR;
            end
            UPD_WR: begin
                wr_en = 1'b1;
                addr  = head_hist;
                if (head_taken) wdata = (bus.tbl_rdata == 2'b11) ? 2'b11 : bus.tbl_rdata + 2'd1;
                else            wdata = (bus.tbl_rdata == 2'b00) ? 2'b00 : bus.tbl_rdata - 2'd1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.tbl_rd_en    = rd_en;
    assign bus.tbl_wr_en    = wr_en;
    assign bus.tbl_addr     = addr;
    assign bus.tbl_wdata    = wdata;
    assign bus.pred_valid   = pred_valid;
    // Direction is live from the table during the response cycle, then held.
    assign bus.pred_taken   = (state == PRED_RSP) ? bus.tbl_rdata[1] : pred_taken_q;
    assign bus.pred_hist    = pred_hist_q;
    assign bus.path_history = path_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (upd_acc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({upd_acc, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue storage is not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clock) begin
        if (upd_acc) begin
            q_hist[wr_ptr]  <= bus.upd_hist;
            q_taken[wr_ptr] <= bus.upd_taken;
        end
    end

    // A mispredict restore overrides the speculative shift on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            path_q       <= '0;
            pred_hist_q  <= '0;
            pred_taken_q <= 1'b0;
        end else begin
            if (upd_acc && bus.upd_mispredict)
                path_q <= {bus.upd_hist[HIST_W-2:0], bus.upd_taken};
            else if (state == PRED_RSP)
                path_q <= {path_q[HIST_W-2:0], bus.tbl_rdata[1]};
            if (state == PRED_RD)  pred_hist_q  <= path_q;
            if (state == PRED_RSP) pred_taken_q <= bus.tbl_rdata[1];
        end
    end
endmodule

// File: tb/tb_global_pred_ctrl.sv
// Scoreboard bench for global_pred_ctrl: stimulus pushes expected predictions and table
// writes into queues, a negedge monitor pops and compares whenever the DUT presents one.
module tb_global_pred_ctrl;
    localparam int HIST_W = 12;

    typedef struct packed {
        logic              taken;
        logic [HIST_W-1:0] hist;
    } pred_exp_t;

    typedef struct packed {
        logic [HIST_W-1:0] addr;
        logic [1:0]        data;
    } wr_exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    pred_exp_t pred_q[$];
    wr_exp_t   wr_q[$];

    global_pred_ctrl_if #(.HIST_W(HIST_W)) bus ();

    global_pred_ctrl #(.HIST_W(HIST_W), .QDEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic upd(input logic [HIST_W-1:0] h, input logic t, input logic m);
        bus.upd_req        = 1'b1;
        bus.upd_hist       = h;
        bus.upd_taken      = t;
        bus.upd_mispredict = m;
        tick();
        bus.upd_req        = 1'b0;
        bus.upd_mispredict = 1'b0;
    endtask

    // Single isolated update from an idle, empty queue: enqueue, UPD_RD, UPD_WR, back to IDLE.
    task automatic do_update(input logic [HIST_W-1:0] h, input logic t,
                             input logic [1:0] rd, input logic [1:0] exp_wd);
        bus.tbl_rdata = rd;
        wr_q.push_back('{addr: h, data: exp_wd});
        upd(h, t, 1'b0);
        tick();
        check("upd_rd_en", 32'(bus.tbl_rd_en), 32'd1);
        check("upd_rd_addr", 32'(bus.tbl_addr), 32'(h));
        tick();
        tick();
    endtask

    // Monitor: compares every presented prediction and table write against the scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.pred_valid) begin
                if (pred_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL pred_unexpected: got taken=%0b hist=0x%0h with nothing expected",
                             bus.pred_taken, bus.pred_hist);
                end else begin
                    pred_exp_t e;
                    e = pred_q.pop_front();
                    check("pred_taken", 32'(bus.pred_taken), 32'(e.taken));
                    check("pred_hist", 32'(bus.pred_hist), 32'(e.hist));
                end
            end
            if (bus.tbl_wr_en) begin
                check("rd_wr_exclusive", 32'(bus.tbl_rd_en), 32'd0);
                if (wr_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got addr=0x%0h data=%0d with nothing expected",
                             bus.tbl_addr, bus.tbl_wdata);
                end else begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    check("wr_addr", 32'(bus.tbl_addr), 32'(w.addr));
                    check("wr_data", 32'(bus.tbl_wdata), 32'(w.data));
                end
            end else begin
                check("wdata_idle_zero", 32'(bus.tbl_wdata), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pred_req       = 1'b0;
        bus.upd_req        = 1'b0;
        bus.upd_hist       = '0;
        bus.upd_taken      = 1'b0;
        bus.upd_mispredict = 1'b0;
        bus.tbl_rdata      = 2'b00;

        // Reset state and first cycle after release.
        tick();
        tick();
        check("rst_tbl_rd_en", 32'(bus.tbl_rd_en), 32'd0);
        check("rst_tbl_wr_en", 32'(bus.tbl_wr_en), 32'd0);
        check("rst_tbl_addr", 32'(bus.tbl_addr), 32'd0);
        reset = 1'b0;
        check("rel_pred_ready", 32'(bus.pred_ready), 32'd1);
        check("rel_upd_ready", 32'(bus.upd_ready), 32'd1);
        check("rel_path", 32'(bus.path_history), 32'd0);
        check("rel_pred_hist", 32'(bus.pred_hist), 32'd0);

        // First prediction: read at addr 0, taken from counter 2'b10, history shifts to 0x001.
        bus.tbl_rdata = 2'b10;
        pred_q.push_back('{taken: 1'b1, hist: 12'h000});
        bus.pred_req = 1'b1;
        tick();
        bus.pred_req = 1'b0;
        check("pred_rd_en", 32'(bus.tbl_rd_en), 32'd1);
        check("pred_rd_addr", 32'(bus.tbl_addr), 32'h000);
        tick();
        tick();
        check("path_after_pred", 32'(bus.path_history), 32'h001);

        // Saturating counter updates at both ends and in the middle.
        do_update(12'h0A5, 1'b1, 2'b11, 2'b11);
        do_update(12'h0A5, 1'b0, 2'b00, 2'b00);
        do_update(12'h0A5, 1'b1, 2'b01, 2'b10);
        do_update(12'h0A5, 1'b0, 2'b10, 2'b01);
        check("path_unchanged_by_upd", 32'(bus.path_history), 32'h001);

        // Fill the queue while pred_req is held; the 5th update is dropped.
        bus.tbl_rdata = 2'b01;
        pred_q.push_back('{taken: 1'b0, hist: 12'h001});
        pred_q.push_back('{taken: 1'b0, hist: 12'h002});
        wr_q.push_back('{addr: 12'h111, data: 2'b10});
        wr_q.push_back('{addr: 12'h222, data: 2'b00});
        wr_q.push_back('{addr: 12'h333, data: 2'b10});
        wr_q.push_back('{addr: 12'h444, data: 2'b00});
        bus.pred_req = 1'b1;
        upd(12'h111, 1'b1, 1'b0);
        upd(12'h222, 1'b0, 1'b0);
        upd(12'h333, 1'b1, 1'b0);
        check("ready_at_count3", 32'(bus.pred_ready), 32'd1);
        upd(12'h444, 1'b0, 1'b0);
        check("full_upd_ready", 32'(bus.upd_ready), 32'd0);
        check("full_pred_ready", 32'(bus.pred_ready), 32'd0);
        upd(12'h555, 1'b1, 1'b0);
        tick();
        check("full_idle_pred_ready", 32'(bus.pred_ready), 32'd0);
        check("full_idle_upd_ready", 32'(bus.upd_ready), 32'd0);
        check("path_after_two_preds", 32'(bus.path_history), 32'h004);
        tick();
        check("drain_first_rd_en", 32'(bus.tbl_rd_en), 32'd1);
        check("drain_first_addr", 32'(bus.tbl_addr), 32'h111);
        bus.pred_req = 1'b0;
        repeat (12) tick();
        check("drained_upd_ready", 32'(bus.upd_ready), 32'd1);
        check("drained_pred_ready", 32'(bus.pred_ready), 32'd1);

        // Mispredict restore: 0xFFF, then 0x123 taken gives 0x247.
        wr_q.push_back('{addr: 12'h7FF, data: 2'b10});
        upd(12'h7FF, 1'b1, 1'b1);
        check("restore_fff", 32'(bus.path_history), 32'hFFF);
        repeat (3) tick();
        wr_q.push_back('{addr: 12'h123, data: 2'b10});
        upd(12'h123, 1'b1, 1'b1);
        check("restore_247", 32'(bus.path_history), 32'h247);
        repeat (3) tick();

        // Restore coinciding with the PRED_RSP shift: the restore wins.
        wr_q.push_back('{addr: 12'h7FF, data: 2'b10});
        upd(12'h7FF, 1'b1, 1'b1);
        repeat (3) tick();
        check("restore_fff_again", 32'(bus.path_history), 32'hFFF);
        pred_q.push_back('{taken: 1'b0, hist: 12'hFFF});
        wr_q.push_back('{addr: 12'h123, data: 2'b10});
        bus.pred_req = 1'b1;
        tick();
        bus.pred_req = 1'b0;
        tick();
        upd(12'h123, 1'b1, 1'b1);
        check("restore_wins", 32'(bus.path_history), 32'h247);
        repeat (3) tick();

        // Ordinary shift from 0x247 with a taken prediction.
        bus.tbl_rdata = 2'b10;
        pred_q.push_back('{taken: 1'b1, hist: 12'h247});
        bus.pred_req = 1'b1;
        tick();
        bus.pred_req = 1'b0;
        tick();
        tick();
        check("shift_48f", 32'(bus.path_history), 32'h48F);

        // Reset during UPD_WR with three entries queued: no strobes, queue discarded.
        bus.tbl_rdata = 2'b01;
        upd(12'h0AA, 1'b1, 1'b0);
        upd(12'h0BB, 1'b1, 1'b0);
        upd(12'h0CC, 1'b1, 1'b0);
        check("in_upd_wr", 32'(bus.tbl_wr_en), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_kills_wr", 32'(bus.tbl_wr_en), 32'd0);
        check("rst_kills_wdata", 32'(bus.tbl_wdata), 32'd0);
        check("rst_path", 32'(bus.path_history), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        check("rel2_pred_ready", 32'(bus.pred_ready), 32'd1);
        check("rel2_upd_ready", 32'(bus.upd_ready), 32'd1);
        check("rel2_path", 32'(bus.path_history), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_no_rd", 32'(bus.tbl_rd_en), 32'd0);
        end

        check("pred_q_empty", 32'(pred_q.size()), 32'd0);
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/global_pred_ctrl.md
GLOBAL_PRED_CTRL -- requirements
Module: global_pred_ctrl

Interface
REQ-001 Parameter HIST_W, 12: global path-history width; counter table depth is 2**HIST_W.
REQ-002 Parameter QDEPTH, 4: update-queue depth, a power of two.
REQ-003 clock  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 pred_req  in  1  fetch requests a global prediction; sampled only while pred_ready=1.
REQ-006 pred_ready  out  1  controller can accept pred_req this cycle.
REQ-007 pred_valid  out  1  one-cycle pulse; pred_taken and pred_hist are valid.
REQ-008 pred_taken  out  1  predicted direction, equal to counter bit [1].
REQ-009 pred_hist  out  HIST_W  history used to index the prediction, returned later with the update.
REQ-010 upd_req  in  1  retire-stage update; accepted when upd_ready=1.
REQ-011 upd_ready  out  1  update queue not full.
REQ-012 upd_hist  in  HIST_W  history that indexed the retiring branch.
REQ-013 upd_taken  in  1  resolved direction.
REQ-014 upd_mispredict  in  1  retiring branch was mispredicted.
REQ-015 tbl_addr  out  HIST_W  address to the single-port counter table.
REQ-016 tbl_rd_en  out  1  table read strobe; tbl_rdata is valid on the following cycle.
REQ-017 tbl_rdata  in  2  counter read data.
REQ-018 tbl_wr_en  out  1  table write strobe.
REQ-019 tbl_wdata  out  2  counter write data.
REQ-020 path_history  out  HIST_W  current speculative global history.

Function
REQ-021 The FSM SHALL have states IDLE, PRED_RD, PRED_RSP, UPD_RD and UPD_WR, and no table access may occur outside PRED_RD, UPD_RD and UPD_WR.
REQ-022 pred_ready SHALL equal (state==IDLE) and (queue count < QDEPTH).
REQ-023 In IDLE, an accepted pred_req SHALL transition to PRED_RD; otherwise a non-empty queue SHALL transition to UPD_RD; otherwise the FSM SHALL remain in IDLE.
REQ-024 When the queue is full, a pending pred_req SHALL be blocked (pred_ready=0) so that the update drains first.
REQ-025 PRED_RD SHALL drive tbl_rd_en=1, tbl_addr=path_history and latch that value into pred_hist, then go to PRED_RSP.
REQ-026 PRED_RSP SHALL pulse pred_valid=1 with pred_taken=tbl_rdata[1], then return to IDLE; pred_req-to-pred_valid latency SHALL be exactly 2 cycles.
REQ-027 In PRED_RSP, path_history SHALL shift to {path_history[HIST_W-2:0], pred_taken}.
REQ-028 UPD_RD SHALL drive tbl_rd_en=1 and tbl_addr=the queue-head hist, then go to UPD_WR.
REQ-029 UPD_WR SHALL drive tbl_wr_en=1 at the same address with a saturating update: taken gives min(c+1,3), not-taken gives max(c-1,0); it SHALL then pop the queue head and return to IDLE.
REQ-030 An update SHALL be enqueued when upd_req=1 and upd_ready=1; enqueue and dequeue in the same cycle SHALL leave the count unchanged, and pointers SHALL wrap modulo QDEPTH.
REQ-031 upd_req while upd_ready=0 SHALL be dropped with no state change.
REQ-032 An accepted update with upd_mispredict=1 SHALL set path_history to {upd_hist[HIST_W-2:0], upd_taken} on that edge.
REQ-033 If a restore and a PRED_RSP shift fall on the same edge, the restore SHALL win; pred_valid still pulses.
REQ-034 tbl_rd_en and tbl_wr_en SHALL never be asserted in the same cycle.
REQ-035 tbl_wdata SHALL be 0 whenever tbl_wr_en=0, and outputs SHALL hold stable between valid pulses.

Reset
REQ-036 Asserting reset SHALL immediately clear state to IDLE, queue count and pointers to 0, and path_history, pred_hist, pred_taken, pred_valid, tbl_rd_en, tbl_wr_en, tbl_addr and tbl_wdata to 0.
REQ-037 Reset mid-operation SHALL abandon any in-flight read or write without issuing a further strobe, and SHALL discard queued updates.
REQ-038 After reset deassertion, pred_ready=1 and upd_ready=1 SHALL hold on the first cycle.

Verification
REQ-039 Reset, pred_req at cycle 1, tbl_rdata=2'b10 -> tbl_rd_en at cycle 2 with addr 0x000; pred_valid=1, pred_taken=1 at cycle 3; path_history=0x001.
REQ-040 Enqueue upd_hist=0x0A5, taken, tbl_rdata=2'b11 -> tbl_wr_en, tbl_wdata=2'b11 (saturation); with not-taken and rdata=2'b00 -> tbl_wdata=2'b00.
REQ-041 Enqueue 4 updates while pred_req is held -> upd_ready=0 and pred_ready=0; the next IDLE services UPD_RD first; a 5th upd_req is dropped.
REQ-042 path_history=0xFFF, accept update with mispredict, upd_hist=0x123, taken -> path_history=0x247 on the next edge, including when it coincides with PRED_RSP.
REQ-043 Assert reset during UPD_WR with 3 entries queued -> no write strobe after reset, count=0, path_history=0, and both ready signals high after release.
